seq_alu: RTL
============

Name: seq_alu

Overview:
- Multi-cycle, size-aware successor to the single-cycle combinational ALU, and the execution unit for the 68000 integer datapath.
- Adds byte/word/long operand sizing, extend ops (ADDX/SUBX) with sticky Z, and bit-serial shifts/rotates (one bit per clock) with 68000 flag semantics.
- Uses a start/busy/done handshake toward the microsequencer. All results and flags are registered.

Parameters:
- BITS, 32, datapath width; must be 32 for long size.
- CNT_BITS, 6, shift count width; count is taken modulo 2^CNT_BITS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  operation request; accepted only when busy=0
- op  in  4  operation code (see Behaviour)
- size  in  2  00 byte, 01 word, 10 long, 11 treated as long
- A  in  BITS  destination operand; also the shift/rotate source
- B  in  BITS  source operand
- count  in  CNT_BITS  shift/rotate count
- X_in  in  1  current X flag
- Z_in  in  1  current Z flag, used by ADDX/SUBX only
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when results are valid
- O  out  BITS  result
- C, X_out, Z, V, N  out  1 each  condition flags

Behaviour:
- Reset: state IDLE; busy=0, done=0, O=0, all flags 0. Reset asserted mid-operation aborts immediately; no done pulse.
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 ADDX, 6 SUBX
  - 7 ASL, 8 ASR, 9 LSL, 10 LSR, 11 ROL, 12 ROR, 13 ROXL, 14 ROXR
  - 15 PASS
- Operands and sizing: operands are latched at the start edge; later input changes are ignored.
  - Sized width w = 8/16/32. Only bits w-1:0 are operated on.
  - O[BITS-1:w] = latched A[BITS-1:w].
  - N, V and C are taken at the sized MSB/carry position.
- States:
  - IDLE: on start, latch operands and go to EXEC.
  - EXEC: arithmetic/logic/PASS ops, and shifts with count=0, complete in one cycle, then go to IDLE with done=1.
  - SHIFT: shifts with count n≥1 perform one bit step per clock for n clocks, then go to IDLE with done=1.
- Latency: start sampled at edge k.
  - Single-cycle ops: done high after edge k+1.
  - Shift of n: done high after edge k+1+n; busy high over edges k..k+n.
- Handshake: start while busy=1 is ignored. O and flags hold their value until the next accepted operation completes.
- ADD/SUB/ADDX/SUBX flags:
  - C = carry/borrow out; X_out = C.
  - V = signed overflow (for SUB, computed on A−B).
  - N = sized MSB.
  - ADDX/SUBX include X_in in the sum/difference.
- Z flag:
  - ADD/SUB/logic: Z = result==0.
  - ADDX/SUBX: Z = Z_in & (result==0).
- AND/OR/XOR/PASS: C=0, V=0, X_out=X_in.
- Shifts:
  - C = last bit shifted out.
  - X_out = C for ASx/LSx/ROXx; X_out = X_in for ROL/ROR.
  - V = 0 except ASL: V=1 if the sized MSB changed at any step.
  - ROXL/ROXR rotate through X.
- Count 0: O=A. C=0, except ROXL/ROXR where C=X_in. X_out=X_in, V=0, N/Z from A.
- Count ≥ w: keep stepping for the full count (no shortcut); the result and flags must match 68000 semantics, e.g. LSR.B by 9 gives 0.
- Simultaneous reset and start: reset wins.

Decomposition:
- Package alu_pkg: op-code constants, size-code constants, and a width-from-size function.
- Sub-module alu_shift_step: combinational one-bit step. Inputs: value, size, op, X. Outputs: next value, bit out, MSB-changed.

Test Plan:
- ADD.B, A=0x123456FF, B=0x00000001, X_in=0 -> O=0x12345600, C=1, X_out=1, Z=1, V=0, N=0; done one cycle after start.
- ADDX.W, A=B=0, X_in=0, Z_in=0 -> Z=0 (sticky). Repeat with Z_in=1 -> Z=1. SUBX.L, A=0, B=0, X_in=1 -> O=0xFFFFFFFF, C=1, N=1.
- ASL.W, A=0x4000, count=3 -> O=0x0000, C=0, X_out=0, V=1, Z=1; done after edge k+4; busy high edges k..k+3.
- ROXR.B, A=0x81, count=0, X_in=1 -> O=0x81, C=1, X_out=1, V=0, N=1; done after 1 cycle. ROL.B, A=0x81, count=1 -> O=0x03, C=1, X_out=X_in.
- LSR.L, A=0xFFFFFFFF, count=63 -> O=0, C=0, X_out=0, Z=1; done exactly 64 cycles after start. A second start asserted mid-run is ignored.
- Reset pulse during an ASR.L count=20 -> busy=0, O=0, flags 0 immediately; no done pulse. The next start runs normally.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared constants for the sequential 68000-style ALU: op codes,
// operand size codes and helpers that map a size code to width and mask.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_ADDX = 4'd5;
    localparam logic [3:0] OP_SUBX = 4'd6;
    localparam logic [3:0] OP_ASL  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_LSL  = 4'd9;
    localparam logic [3:0] OP_LSR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_ROXL = 4'd13;
    localparam logic [3:0] OP_ROXR = 4'd14;
    localparam logic [3:0] OP_PASS = 4'd15;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;

    function automatic logic [5:0] width_of(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 6'd8;
            SZ_WORD: return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 32'h0000_00FF;
            SZ_WORD: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op >= OP_ASL) && (op <= OP_ROXR);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// start/busy/done handshake plus operand and result bundle of seq_alu.
// master: sequencer side (drives request); slave: the ALU.
interface seq_alu_if #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 6
);
    logic                start;
    logic [3:0]          op;
    logic [1:0]          size;
    logic [BITS-1:0]     A;
    logic [BITS-1:0]     B;
    logic [CNT_BITS-1:0] count;
    logic                X_in;
    logic                Z_in;
    logic                busy;
    logic                done;
    logic [BITS-1:0]     O;
    logic                C;
    logic                X_out;
    logic                Z;
    logic                V;
    logic                N;

    modport master (
        output start, op, size, A, B, count, X_in, Z_in,
        input  busy, done, O, C, X_out, Z, V, N
    );

    modport slave (
        input  start, op, size, A, B, count, X_in, Z_in,
        output busy, done, O, C, X_out, Z, V, N
    );
endinterface

// File: rtl/seq_alu_shift_step.sv
// One-bit shift/rotate step on the sized low field of i_val; bits above
// the sized width pass through. Ports: i_val/i_size/i_op/i_x in,
// o_val (stepped value), o_out (bit shifted out), o_msb_chg out.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] i_val,
    input  logic [1:0]      i_size,
    input  logic [3:0]      i_op,
    input  logic            i_x,
    output logic [BITS-1:0] o_val,
    output logic            o_out,
    output logic            o_msb_chg
);
    localparam int IW = $clog2(BITS);

    logic [BITS-1:0] w_mask;
    logic [BITS-1:0] w_sh;
    logic [IW-1:0]   w_msb;
    logic            w_top;
    logic            w_fill;
    logic            w_left;

    assign w_mask = BITS'(mask_of(i_size));
    assign w_msb  = IW'(width_of(i_size) - 6'd1);
    assign w_top  = i_val[w_msb];

    always_comb begin
        w_left = 1'b0;
        w_fill = 1'b0;
        case (i_op)
            OP_ASL, OP_LSL: w_left = 1'b1;
            OP_ROL: begin
                w_left = 1'b1;
                w_fill = w_top;
            end
            OP_ROXL: begin
                w_left = 1'b1;
                w_fill = i_x;
            end
            OP_ASR:  w_fill = w_top;
            OP_ROR:  w_fill = i_val[0];
            OP_ROXR: w_fill = i_x;
            default: w_fill = 1'b0;
        endcase
        if (w_left) begin
            w_sh  = (i_val << 1) | BITS'(w_fill);
            o_out = w_top;
        end else begin
            // clear upper bits first so they cannot leak into the field
            w_sh  = ((i_val & w_mask) >> 1) | (BITS'(w_fill) << w_msb);
            o_out = i_val[0];
        end
        o_val     = (i_val & ~w_mask) | (w_sh & w_mask);
        o_msb_chg = o_val[w_msb] ^ w_top;
    end
endmodule

// File: rtl/seq_alu.sv
// Multi-cycle size-aware ALU: one-cycle arith/logic, bit-serial shifts.
// Ports: clk, reset (async, active high), bus (seq_alu_if slave).
module seq_alu
    import alu_pkg::*;
#(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 6
) (
    input logic  clk,
    input logic  reset,
    seq_alu_if.slave bus
);
    localparam int IW = $clog2(BITS);
    localparam int CW = $clog2(BITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;

    logic [1:0]          r_state;
    logic [3:0]          r_op;
    logic [1:0]          r_size;
    logic [BITS-1:0]     r_a;
    logic [BITS-1:0]     r_b;
    logic [CNT_BITS-1:0] r_cnt;
    logic                r_xin;
    logic                r_zin;
    logic [BITS-1:0]     r_val;
    logic                r_x;
    logic                r_vs;
    logic                r_done;
    logic [BITS-1:0]     r_o;
    logic                r_c;
    logic                r_xo;
    logic                r_z;
    logic                r_v;
    logic                r_n;

    logic [BITS-1:0] w_mask;
    logic [IW-1:0]   w_msb;
    logic [CW-1:0]   w_cpos;
    logic [BITS-1:0] w_a;
    logic [BITS-1:0] w_b;
    logic            w_cin;
    logic [BITS:0]   w_sum;
    logic [BITS:0]   w_dif;
    logic [BITS-1:0] w_res;
    logic [BITS-1:0] w_o;
    logic            w_c;
    logic            w_xo;
    logic            w_v;
    logic            w_z;
    logic            w_zero;
    logic [BITS-1:0] w_next;
    logic            w_bit;
    logic            w_chg;

    assign w_mask = BITS'(mask_of(r_size));
    assign w_msb  = IW'(width_of(r_size) - 6'd1);
    assign w_cpos = CW'(width_of(r_size));
    assign w_a    = r_a & w_mask;
    assign w_b    = r_b & w_mask;
    assign w_cin  = ((r_op == OP_ADDX) || (r_op == OP_SUBX)) & r_xin;
    // operands are masked, so the carry/borrow lands exactly at bit w
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {{BITS{1'b0}}, w_cin};
    assign w_dif  = {1'b0, w_a} - {1'b0, w_b} - {{BITS{1'b0}}, w_cin};

    always_comb begin
        w_res = w_a;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_xo  = r_xin;
        case (r_op)
            OP_ADD, OP_ADDX: begin
                w_res = w_sum[BITS-1:0];
                w_c   = w_sum[w_cpos];
                w_xo  = w_c;
                w_v   = (w_a[w_msb] == w_b[w_msb]) &&
                        (w_res[w_msb] != w_a[w_msb]);
            end
            OP_SUB, OP_SUBX: begin
                w_res = w_dif[BITS-1:0];
                w_c   = w_dif[w_cpos];
                w_xo  = w_c;
                w_v   = (w_a[w_msb] != w_b[w_msb]) &&
                        (w_res[w_msb] != w_a[w_msb]);
            end
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            // zero-count rotate through X reports X as carry
            OP_ROXL, OP_ROXR: w_c = r_xin;
            default: w_res = w_a;
        endcase
        w_zero = (w_res & w_mask) == '0;
        w_z    = ((r_op == OP_ADDX) || (r_op == OP_SUBX)) ?
                 (r_zin & w_zero) : w_zero;
        w_o    = (r_a & ~w_mask) | (w_res & w_mask);
    end

    alu_shift_step #(.BITS(BITS)) u_step (
        .i_val     (r_val),
        .i_size    (r_size),
        .i_op      (r_op),
        .i_x       (r_x),
        .o_val     (w_next),
        .o_out     (w_bit),
        .o_msb_chg (w_chg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_size  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_xin   <= 1'b0;
            r_zin   <= 1'b0;
            r_val   <= '0;
            r_x     <= 1'b0;
            r_vs    <= 1'b0;
            r_done  <= 1'b0;
            r_o     <= '0;
            r_c     <= 1'b0;
            r_xo    <= 1'b0;
            r_z     <= 1'b0;
            r_v     <= 1'b0;
            r_n     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_size  <= bus.size;
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_cnt   <= bus.count;
                        r_xin   <= bus.X_in;
                        r_zin   <= bus.Z_in;
                        r_val   <= bus.A;
                        r_x     <= bus.X_in;
                        r_vs    <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_shift(r_op) && (r_cnt != '0)) begin
                        r_state <= S_SHIFT;
                    end else begin
                        r_o     <= w_o;
                        r_c     <= w_c;
                        r_xo    <= w_xo;
                        r_z     <= w_z;
                        r_v     <= w_v;
                        r_n     <= w_res[w_msb];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_val <= w_next;
                    r_x   <= w_bit;
                    r_vs  <= r_vs | w_chg;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_BITS'(1)) begin
                        r_o     <= w_next;
                        r_c     <= w_bit;
                        r_xo    <= ((r_op == OP_ROL) || (r_op == OP_ROR)) ?
                                   r_xin : w_bit;
                        r_z     <= (w_next & w_mask) == '0;
                        r_v     <= (r_op == OP_ASL) & (r_vs | w_chg);
                        r_n     <= w_next[w_msb];
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = (r_state != S_IDLE);
    assign bus.done  = r_done;
    assign bus.O     = r_o;
    assign bus.C     = r_c;
    assign bus.X_out = r_xo;
    assign bus.Z     = r_z;
    assign bus.V     = r_v;
    assign bus.N     = r_n;
endmodule
